// File: rtl/mul_seq_if.sv
// mul_seq_if: start/fin handshake and operand/product bus for mul_seq; sgn exists only with MUL_SIGNED_EN
interface mul_seq_if #(
  parameter int WIDTH = 8
) ();
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] O;
  logic               busy;
  logic               fin;
`ifdef MUL_SIGNED_EN
  logic               sgn;
  modport master (output start, A, B, sgn, input O, busy, fin);
  modport slave  (input start, A, B, sgn, output O, busy, fin);
`else
  modport master (output start, A, B, input O, busy, fin);
  modport slave  (input start, A, B, output O, busy, fin);
`endif
endinterface

// File: rtl/mul_seq.sv
// mul_seq: MSB-first shift-add multiplier, one multiplier bit per clock; MUL_SIGNED_EN adds two's-complement mode
module mul_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input logic      ck,
  input logic      rst_n,
  mul_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             st;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   aq;
  logic [WIDTH-1:0]   bq;
  logic [2*WIDTH-1:0] y;
  logic [2*WIDTH-1:0] y_nx;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] o_q;
  logic               b_bit;
  logic               busy_q;
  logic               fin_q;
`ifdef MUL_SIGNED_EN
  logic               sq;
`endif
  assign bus.O    = o_q;
  assign bus.busy = busy_q;
  assign bus.fin  = fin_q;
  // next partial product: shift left and add the multiplicand when the current multiplier bit is set
  always_comb begin
    b_bit = |(bq & (WIDTH'(1) << cnt));
`ifdef MUL_SIGNED_EN
    a_ext = {{WIDTH{sq & aq[WIDTH-1]}}, aq};
    y_nx  = (sq && b_bit && cnt == CW'(WIDTH - 1)) ? (y << 1) - a_ext
                                                    : (y << 1) + (b_bit ? a_ext : '0);
`else
    a_ext = {{WIDTH{1'b0}}, aq};
    y_nx  = (y << 1) + (b_bit ? a_ext : '0);
`endif
  end
  // control FSM and datapath registers; start always wins and restarts the sequence
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      cnt    <= '0;
      aq     <= '0;
      bq     <= '0;
      y      <= '0;
      o_q    <= '0;
      busy_q <= 1'b0;
      fin_q  <= 1'b0;
`ifdef MUL_SIGNED_EN
      sq     <= 1'b0;
`endif
    end else if (bus.start) begin
      st     <= RUN;
      cnt    <= CW'(WIDTH - 1);
      aq     <= bus.A;
      bq     <= bus.B;
      y      <= '0;
      o_q    <= '0;
      busy_q <= 1'b1;
      fin_q  <= 1'b0;
`ifdef MUL_SIGNED_EN
      sq     <= bus.sgn;
`endif
    end else begin
      case (st)
        RUN: begin
          y <= y_nx;
          if (cnt == '0) begin
            st     <= DONE;
            o_q    <= y_nx;
            busy_q <= 1'b0;
            fin_q  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          st    <= IDLE;
          fin_q <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed checks of mul_seq at WIDTH=8 and WIDTH=16 (signed cases when MUL_SIGNED_EN is defined)
module tb_mul_seq;
  logic ck = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n;
  mul_seq_if #(.WIDTH(8))  i8 ();
  mul_seq_if #(.WIDTH(16)) i16 ();
  mul_seq #(.WIDTH(8))  d8  (.ck(ck), .rst_n(rst_n), .bus(i8.slave));
  mul_seq #(.WIDTH(16)) d16 (.ck(ck), .rst_n(rst_n), .bus(i16.slave));
  always #5 ck = ~ck;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge ck);
    #1;
  endtask
  task automatic start_op(input bit w, input logic [31:0] a, input logic [31:0] b, input bit s);
    if (w) begin
      i16.A = a[15:0];
      i16.B = b[15:0];
      i16.start = 1'b1;
    end else begin
      i8.A = a[7:0];
      i8.B = b[7:0];
      i8.start = 1'b1;
    end
`ifdef MUL_SIGNED_EN
    i8.sgn = s;
    i16.sgn = 1'b0;
`else
    if (s) $display("note: signed step skipped in unsigned build");
`endif
    tick;
    i8.start = 1'b0;
    i16.start = 1'b0;
  endtask
  task automatic wait_fin(input bit w, output int cnt);
    cnt = 0;
    do begin
      tick;
      cnt++;
    end while (!(w ? i16.fin : i8.fin) && cnt < 40);
  endtask
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input bit s, input logic [31:0] exp);
    start_op(1'b0, {24'h0, a}, {24'h0, b}, s);
    wait_fin(1'b0, n);
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_o"}, {16'h0, i8.O}, exp);
  endtask
  initial begin
    i8.start = 1'b0;
    i8.A = '0;
    i8.B = '0;
    i16.start = 1'b0;
    i16.A = '0;
    i16.B = '0;
`ifdef MUL_SIGNED_EN
    i8.sgn = 1'b0;
    i16.sgn = 1'b0;
`endif
    #3 rst_n = 1'b0;
    #1;
    chk("rst_o", {16'h0, i8.O}, 0);
    chk("rst_busy", {31'h0, i8.busy}, 0);
    chk("rst_fin", {31'h0, i8.fin}, 0);
    #10 rst_n = 1'b1;
    tick;
    tick;
    chk("idle_busy", {31'h0, i8.busy}, 0);
    start_op(1'b0, 13, 11, 1'b0);
    chk("t0_busy", {31'h0, i8.busy}, 1);
    chk("t0_o", {16'h0, i8.O}, 0);
    for (int i = 1; i < 8; i++) begin
      tick;
      chk("run_busy", {31'h0, i8.busy}, 1);
      chk("run_fin", {31'h0, i8.fin}, 0);
    end
    tick;
    chk("fin13", {31'h0, i8.fin}, 1);
    chk("o13", {16'h0, i8.O}, 143);
    chk("busy_done", {31'h0, i8.busy}, 0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("hold_o", {16'h0, i8.O}, 143);
      chk("hold_fin", {31'h0, i8.fin}, 0);
    end
    run8("ff", 8'hFF, 8'hFF, 1'b0, 32'hFE01);
    run8("zero", 8'd0, 8'd200, 1'b0, 0);
    run8("one", 8'd1, 8'd1, 1'b0, 1);
    start_op(1'b0, 20, 30, 1'b0);
    tick;
    tick;
    tick;
    start_op(1'b0, 7, 9, 1'b0);
    wait_fin(1'b0, n);
    chk("abort_lat", n, 8);
    chk("abort_o", {16'h0, i8.O}, 63);
    start_op(1'b0, 100, 100, 1'b0);
    tick;
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'h0, i8.busy}, 0);
    chk("arst_fin", {31'h0, i8.fin}, 0);
    chk("arst_o", {16'h0, i8.O}, 0);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      chk("post_rst_idle", {15'h0, i8.busy, i8.fin, i8.O}, 0);
    end
    run8("three5", 8'd3, 8'd5, 1'b0, 15);
`ifdef MUL_SIGNED_EN
    run8("s_m3x5", 8'hFD, 8'h05, 1'b1, 32'hFFF1);
    run8("s_m128sq", 8'h80, 8'h80, 1'b1, 32'h4000);
    run8("s_127xm1", 8'h7F, 8'hFF, 1'b1, 32'hFF81);
    run8("u_fdx5", 8'hFD, 8'h05, 1'b0, 32'h04F1);
`endif
    start_op(1'b1, 32'hFFFF, 32'hFFFF, 1'b0);
    wait_fin(1'b1, n);
    chk("w16_lat", n, 16);
    chk("w16_o", i16.O, 32'hFFFE0001);
    start_op(1'b1, 32'd300, 32'd1000, 1'b0);
    chk("b2b_busy", {31'h0, i16.busy}, 1);
    chk("b2b_fin", {31'h0, i16.fin}, 0);
    chk("b2b_o0", i16.O, 0);
    wait_fin(1'b1, n);
    chk("b2b_lat", n, 16);
    chk("b2b_o", i16.O, 32'd300000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
